dram_cache_miss_requester: RTL and testbench

- Cache-side initiator for the DRAM controller's read/writeback lane protocol.
- Accepts line-miss requests from cache control logic, queues them, and drives the controller's request, address, dirty and victim-lane inputs.
- Issues a single-cycle read request pulse, waits for the single-cycle ack pulse, captures the 128-bit fill lane and hands it back to the cache with a valid/ready handshake.

---
 rtl/dram_if_pkg.sv | 23 ++
 rtl/miss_req_fifo.sv | 47 ++++
 rtl/dram_cache_miss_requester.sv | 171 +++++++++++++++++
 tb/tb_dram_cache_miss_requester.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_if_pkg.sv
// Shared types and widths for the cache-side DRAM read/writeback lane interface.
package dram_if_pkg;

  localparam int LANE_W   = 128;
  localparam int ADDR_W   = 22;
  localparam int COMMON_W = 9;
  localparam int UPPER_W  = 13;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr_read;
    logic [UPPER_W-1:0] victim_upper;
    logic               dirty;
    logic [LANE_W-1:0]  victim_lane;
  } miss_req_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    DELIVER  = 2'd3
  } req_state_e;

endpackage

// File: rtl/miss_req_fifo.sv
// Synchronous miss-request FIFO; pointers carry an extra wrap bit to tell full from empty.
module miss_req_fifo
  import dram_if_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      main_clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  logic      i_pop,
  input  miss_req_t i_wdata,
  output miss_req_t o_rdata,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  miss_req_t        r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset: an entry is only read after it has been written.
  always_ff @(posedge main_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/dram_cache_miss_requester.sv
// Cache-side initiator: queues line misses, pulses the DRAM controller, returns fills.
// Optional DRAM_REQ_TIMEOUT_EN adds a WAIT_ACK abort counter and sticky err_timeout.
module dram_cache_miss_requester
  import dram_if_pkg::*;
#(
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                main_clk,
  input  logic                rst_n,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [ADDR_W-1:0]   miss_addr_read,
  input  logic [UPPER_W-1:0]  miss_addr_victim_upper,
  input  logic                miss_dirty,
  input  logic [LANE_W-1:0]   miss_victim_lane,
  output logic                fill_valid,
  input  logic                fill_ready,
  output logic [ADDR_W-1:0]   fill_addr,
  output logic [LANE_W-1:0]   fill_lane,
  output logic [UPPER_W-1:0]  addr_req_read_dram_side_dram,
  output logic [UPPER_W-1:0]  addr_req_write_dram_side_dram,
  output logic [COMMON_W-1:0] addr_req_common_side_dram,
  output logic [LANE_W-1:0]   lane_from_cache_to_dram_side_dram,
  output logic                dram_controller_entry_dirty_side_dram,
  output logic                dram_controller_req_read_pulse_side_dram,
  input  logic                dram_controller_ack_read_pulse_side_dram,
  input  logic [LANE_W-1:0]   lane_from_dram_to_cache_side_dram,
  output logic                busy,
  output logic                err_spurious_ack
`ifdef DRAM_REQ_TIMEOUT_EN
  ,
  output logic                err_timeout
`endif
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("dram_cache_miss_requester: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  req_state_e        r_state;
  miss_req_t         r_hold;
  logic              r_pulse;
  logic              r_fill_valid;
  logic [ADDR_W-1:0] r_fill_addr;
  logic [LANE_W-1:0] r_fill_lane;
  logic              r_err_spur;
  logic              r_alive;

  miss_req_t         w_head;
  miss_req_t         w_wdata;
  logic              w_full;
  logic              w_empty;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_ack;
  logic              w_timeout;

  assign w_ack = dram_controller_ack_read_pulse_side_dram;

  // r_alive keeps miss_ready low while (and right after) reset is asserted.
  assign w_ready = r_alive && !w_full;
  assign w_push  = miss_valid && w_ready;
  assign w_pop   = ((r_state == WAIT_ACK) && w_ack) || w_timeout;

  assign w_wdata.addr_read    = miss_addr_read;
  assign w_wdata.victim_upper = miss_addr_victim_upper;
  assign w_wdata.dirty        = miss_dirty;
  assign w_wdata.victim_lane  = miss_victim_lane;

  miss_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .main_clk (main_clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_wdata  (w_wdata),
    .o_rdata  (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

`ifdef DRAM_REQ_TIMEOUT_EN
  localparam int TO_CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W    = (TO_CLOG > 10) ? TO_CLOG : 10;

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_to;

  assign w_timeout   = (r_state == WAIT_ACK) && !w_ack &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign err_timeout = r_err_to;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_pulse      <= 1'b0;
      r_fill_valid <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_lane  <= '0;
      r_err_spur   <= 1'b0;
      r_alive      <= 1'b0;
`ifdef DRAM_REQ_TIMEOUT_EN
      r_to_cnt     <= '0;
      r_err_to     <= 1'b0;
`endif
    end else begin
      r_alive <= 1'b1;
      r_pulse <= 1'b0;
      if (w_ack && (r_state != WAIT_ACK)) r_err_spur <= 1'b1;
      case (r_state)
        IDLE: begin
          if (!w_empty && !r_fill_valid) begin
            r_hold  <= w_head;
            r_pulse <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= WAIT_ACK;
`ifdef DRAM_REQ_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
        end
        WAIT_ACK: begin
          if (w_ack) begin
            r_fill_lane  <= lane_from_dram_to_cache_side_dram;
            r_fill_addr  <= r_hold.addr_read;
            r_fill_valid <= 1'b1;
            r_state      <= DELIVER;
          end
`ifdef DRAM_REQ_TIMEOUT_EN
          else if (w_timeout) begin
            r_err_to <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
`endif
        end
        DELIVER: begin
          if (fill_ready) begin
            r_fill_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Controller-facing fields come only from the hold register so they stay put until the ack.
  assign addr_req_read_dram_side_dram          = r_hold.addr_read[ADDR_W-1:COMMON_W];
  assign addr_req_common_side_dram             = r_hold.addr_read[COMMON_W-1:0];
  assign addr_req_write_dram_side_dram         = r_hold.victim_upper;
  assign dram_controller_entry_dirty_side_dram = r_hold.dirty;
  assign lane_from_cache_to_dram_side_dram     = r_hold.victim_lane;
  assign dram_controller_req_read_pulse_side_dram = r_pulse;

  assign miss_ready       = w_ready;
  assign fill_valid       = r_fill_valid;
  assign fill_addr        = r_fill_addr;
  assign fill_lane        = r_fill_lane;
  assign busy             = !w_empty || (r_state != IDLE);
  assign err_spurious_ack = r_err_spur;

endmodule

// File: tb/tb_dram_cache_miss_requester.sv
// Directed bench for dram_cache_miss_requester with a transaction-level reference model.
module tb_dram_cache_miss_requester;
  import dram_if_pkg::*;

  localparam int DEPTH = 2;
  localparam int TO    = 15;

  logic          main_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          miss_valid = 1'b0;
  logic          miss_ready;
  logic [21:0]   miss_addr_read = '0;
  logic [12:0]   miss_addr_victim_upper = '0;
  logic          miss_dirty = 1'b0;
  logic [127:0]  miss_victim_lane = '0;
  logic          fill_valid;
  logic          fill_ready = 1'b0;
  logic [21:0]   fill_addr;
  logic [127:0]  fill_lane;
  logic [12:0]   rd_up, wr_up;
  logic [8:0]    common;
  logic [127:0]  vlane;
  logic          dirty_o, pulse;
  logic          ack = 1'b0;
  logic [127:0]  lane_in = '0;
  logic          busy, err_spur;
`ifdef DRAM_REQ_TIMEOUT_EN
  logic          err_to;
`endif

  dram_cache_miss_requester #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .main_clk                                 (main_clk),
    .rst_n                                    (rst_n),
    .miss_valid                               (miss_valid),
    .miss_ready                               (miss_ready),
    .miss_addr_read                           (miss_addr_read),
    .miss_addr_victim_upper                   (miss_addr_victim_upper),
    .miss_dirty                               (miss_dirty),
    .miss_victim_lane                         (miss_victim_lane),
    .fill_valid                               (fill_valid),
    .fill_ready                               (fill_ready),
    .fill_addr                                (fill_addr),
    .fill_lane                                (fill_lane),
    .addr_req_read_dram_side_dram             (rd_up),
    .addr_req_write_dram_side_dram            (wr_up),
    .addr_req_common_side_dram                (common),
    .lane_from_cache_to_dram_side_dram        (vlane),
    .dram_controller_entry_dirty_side_dram    (dirty_o),
    .dram_controller_req_read_pulse_side_dram (pulse),
    .dram_controller_ack_read_pulse_side_dram (ack),
    .lane_from_dram_to_cache_side_dram        (lane_in),
    .busy                                     (busy),
    .err_spurious_ack                         (err_spur)
`ifdef DRAM_REQ_TIMEOUT_EN
    ,
    .err_timeout                              (err_to)
`endif
  );

  always #5 main_clk = ~main_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: request queue plus the current transaction phase
  miss_req_t    mq[$];
  miss_req_t    m_hold;
  logic         m_pulse, m_wait, m_fillv, m_err, m_alive, m_to;
  logic [21:0]  m_faddr;
  logic [127:0] m_flane;
  int           m_wcnt;
  logic [21:0]  fill_log[$];

  initial forever begin
    int        sz;
    logic      push;
    miss_req_t r;
    @(posedge main_clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_hold = '0; m_pulse = 0; m_wait = 0; m_fillv = 0; m_err = 0;
      m_alive = 0; m_to = 0; m_faddr = '0; m_flane = '0; m_wcnt = 0;
    end else begin
      cyc++;
      sz   = mq.size();
      push = miss_valid && m_alive && (sz < DEPTH);
      if (ack && !m_wait) m_err = 1;
      if (m_pulse) begin
        m_pulse = 0; m_wait = 1; m_wcnt = 0;
      end else if (m_wait) begin
        if (ack) begin
          m_fillv = 1; m_flane = lane_in; m_faddr = mq[0].addr_read;
          void'(mq.pop_front());
          m_wait = 0;
        end
`ifdef DRAM_REQ_TIMEOUT_EN
        else begin
          m_wcnt++;
          if (m_wcnt == TO) begin
            m_to = 1; m_wait = 0;
            void'(mq.pop_front());
          end
        end
`endif
      end else if (m_fillv) begin
        if (fill_ready) m_fillv = 0;
      end else if (sz > 0) begin
        m_hold = mq[0]; m_pulse = 1;
      end
      if (push) begin
        r.addr_read = miss_addr_read; r.victim_upper = miss_addr_victim_upper;
        r.dirty = miss_dirty; r.victim_lane = miss_victim_lane;
        mq.push_back(r);
      end
      m_alive = 1;
    end
  end

  // ---------------- per-cycle compare, mid-cycle
  initial forever begin
    @(negedge main_clk);
    if (rst_n) begin
      chk("miss_ready", miss_ready, m_alive && (mq.size() < DEPTH));
      chk("busy", busy, (mq.size() > 0) || m_pulse || m_wait || m_fillv);
      chk("req_pulse", pulse, m_pulse);
      chk("fill_valid", fill_valid, m_fillv);
      chk("fill_addr", fill_addr, m_faddr);
      chk("fill_lane", fill_lane, m_flane);
      chk("addr_read_upper", rd_up, m_hold.addr_read[21:9]);
      chk("addr_common", common, m_hold.addr_read[8:0]);
      chk("addr_write", wr_up, m_hold.victim_upper);
      chk("dirty_out", dirty_o, m_hold.dirty);
      chk("victim_lane", vlane, m_hold.victim_lane);
      chk("err_spurious_ack", err_spur, m_err);
`ifdef DRAM_REQ_TIMEOUT_EN
      chk("err_timeout", err_to, m_to);
`endif
      if (fill_valid && fill_ready) fill_log.push_back(fill_addr);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus helpers; all drives happen 1 time unit after a posedge
  task automatic tick(input int n = 1);
    repeat (n) @(posedge main_clk);
    #1;
  endtask

  task automatic push(input logic [21:0] a, input logic [12:0] vu, input logic d,
                      input logic [127:0] vl);
    int guard = 0;
    miss_valid = 1; miss_addr_read = a; miss_addr_victim_upper = vu;
    miss_dirty = d; miss_victim_lane = vl;
    while (!miss_ready && guard < 200) begin tick(); guard++; end
    chk("push_accept_in_bound", guard < 200, 1);
    tick();
    miss_valid = 0;
  endtask

  task automatic wait_pulse(output int lat);
    lat = 0;
    while (!pulse && lat < 200) begin tick(); lat++; end
    chk("pulse_seen_in_bound", lat < 200, 1);
  endtask

  task automatic send_ack(input logic [127:0] l);
    ack = 1; lane_in = l;
    tick();
    ack = 0; lane_in = '0;
  endtask

  task automatic all_zero_check();
    chk("rst_miss_ready", miss_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_fill_addr", fill_addr, 0);
    chk("rst_fill_lane", fill_lane, 0);
    chk("rst_addr_read", rd_up, 0);
    chk("rst_addr_write", wr_up, 0);
    chk("rst_common", common, 0);
    chk("rst_victim_lane", vlane, 0);
    chk("rst_dirty", dirty_o, 0);
    chk("rst_err_spur", err_spur, 0);
  endtask

  localparam logic [127:0] LANE_CLEAN = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] LANE_A5    = {16{8'hA5}};

  initial begin
    int lat, last_ack, n;
    logic [21:0] exp_order[3];
    #1;
    all_zero_check();
    tick(2);
    rst_n = 1;
    tick(2);

    // clean miss
    push(22'h0ABCDE, 13'h0000, 0, '0);
    wait_pulse(lat);
    chk("push_to_pulse_latency", lat, 1);
    chk("clean_common", common, 9'h0DE);
    chk("clean_read_upper", rd_up, 13'h055E);
    tick(9);
    send_ack(LANE_CLEAN);
    chk("clean_fill_valid", fill_valid, 1);
    chk("clean_fill_addr", fill_addr, 22'h0ABCDE);
    chk("clean_fill_lane", fill_lane, LANE_CLEAN);
    fill_ready = 1; tick(); fill_ready = 0;
    chk("clean_fill_done", fill_valid, 0);

    // dirty miss: writeback fields constant from pulse through ack
    push(22'h155123, 13'h1FFF, 1, LANE_A5);
    wait_pulse(lat);
    for (int i = 0; i < 7; i++) begin
      chk("dirty_write_addr", wr_up, 13'h1FFF);
      chk("dirty_flag", dirty_o, 1);
      chk("dirty_victim_lane", vlane, LANE_A5);
      if (i < 6) tick();
    end
    send_ack(~LANE_A5);
    chk("dirty_write_addr_at_ack", wr_up, 13'h1FFF);
    chk("dirty_victim_lane_at_ack", vlane, LANE_A5);
    chk("dirty_fill_lane", fill_lane, ~LANE_A5);
    fill_ready = 1; tick(); fill_ready = 0;

    // back-to-back with a full queue
    fill_log.delete();
    exp_order[0] = 22'h000111; exp_order[1] = 22'h3FF200; exp_order[2] = 22'h012345;
    fill_ready = 1;
    last_ack = 0;
    fork
      begin
        push(exp_order[0], 13'h0001, 0, 128'h1);
        push(exp_order[1], 13'h0002, 1, 128'h2);
        chk("b2b_full_after_two", miss_ready, 0);
        push(exp_order[2], 13'h0003, 0, 128'h3);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          int pl;
          wait_pulse(pl);
          if (i > 0) chk("ack_to_pulse_gap", (cyc - last_ack) >= 2, 1);
          tick(3);
          send_ack(128'hF0 + 128'(i));
          last_ack = cyc;
        end
      end
    join
    tick(3);
    fill_ready = 0;
    chk("b2b_fill_count", fill_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < fill_log.size()) chk("b2b_fill_order", fill_log[i], exp_order[i]);

    // backpressure with a spurious ack injected while the fill is held
    push(22'h2AAAAA, 13'h0555, 1, 128'h55);
    wait_pulse(lat);
    tick(2);
    send_ack(128'hBEEF);
    push(22'h011111, 13'h0777, 0, 128'h77);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) send_ack(128'hDEAD); else tick();
      chk("bp_fill_valid_held", fill_valid, 1);
      chk("bp_fill_lane_held", fill_lane, 128'hBEEF);
      chk("bp_no_new_pulse", pulse, 0);
    end
    chk("spurious_ack_flag", err_spur, 1);
    fill_ready = 1; tick(); fill_ready = 0;
    wait_pulse(lat);
    chk("bp_next_addr", common, 9'h111);
    tick();
    send_ack(128'h1234);
    fill_ready = 1; tick(2); fill_ready = 0;

    // asynchronous reset while waiting for an ack
    push(22'h3C3C3C, 13'h1234, 1, 128'hCAFE);
    wait_pulse(lat);
    tick(3);
    #2 rst_n = 0;
    #1;
    all_zero_check();
    tick(2);
    rst_n = 1;
    tick(2);
    chk("post_reset_ready", miss_ready, 1);

`ifdef DRAM_REQ_TIMEOUT_EN
    push(22'h0F0F0F, 13'h0101, 0, 128'h9);
    push(22'h00A0B0, 13'h0202, 0, 128'hA);
    wait_pulse(lat);
    n = 0;
    while (!err_to && n < 60) begin tick(); n++; end
    chk("timeout_cycle", n, 16);
    chk("timeout_no_fill", fill_valid, 0);
    wait_pulse(lat);
    chk("timeout_next_issued", {rd_up, common}, 22'h00A0B0);
    send_ack(128'h77);
    fill_ready = 1; tick(2); fill_ready = 0;
`else
    n = 0;
`endif

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
